pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register for the RISC-V core; replaces the hard-wired per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle plus a control bundle with a valid/ready handshake, stall hold, synchronous flush and bubble insertion.
- Optional skid mode gives full throughput with a registered ready, for stages whose downstream ready is timing-critical.

Parameters:
- DATA_W, 69: width of the data bundle (e.g. rd 5 + rs2 data 32 + ALU result 32).
- CTRL_W, 4: width of the control bundle.
- CTRL_CLR_MASK, 4'b1111: control bits forced to 0 whenever the stage holds a bubble.
- SKID, 0: 0 = single-entry stall register; 1 = two-entry skid buffer.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- start_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush (branch mispredict or exception).
- in_valid_i  in  1  upstream has a valid bundle.
- in_ready_o  out  1  stage can accept a bundle this cycle.
- in_ctrl_i  in  CTRL_W  control bundle in.
- in_data_i  in  DATA_W  data bundle in.
- out_valid_o  out  1  output bundle valid.
- out_ready_i  in  1  downstream accepts the output bundle.
- out_ctrl_o  out  CTRL_W  control bundle out.
- out_data_o  out  DATA_W  data bundle out.
- count_o  out  2  occupancy, 0..2 (0..1 when SKID=0).

Behaviour:
- Reset (start_i=0, asynchronous, no clock needed):
  - out_valid_o=0, out_ctrl_o=0, out_data_o=0, count_o=0, skid entry empty.
  - in_ready_o=1 once start_i is high.
  - Reset asserted mid-transfer discards all held bundles.
- Handshake:
  - Input accepted at an edge when in_valid_i & in_ready_o.
  - Output consumed when out_valid_o & out_ready_i.
  - Latency: 1 cycle, input to out_valid_o.
- Hold: while out_valid_o=1 and out_ready_i=0, out_ctrl_o and out_data_o are stable.
- Ordering: bundles leave in acceptance order; no drop or duplicate except on flush.
- SKID=0:
  - in_ready_o = out_ready_i | ~out_valid_o (combinational).
  - On accept, the main register loads the input; a simultaneous consume and accept is a back-to-back transfer.
  - On consume without accept, valid goes to 0.
- SKID=1:
  - in_ready_o = ~skid_valid, driven directly from a flop.
  - States: EMPTY (main invalid), BUSY (main valid, skid empty), FULL (both valid).
  - EMPTY: accept -> BUSY.
  - BUSY: accept & consume -> BUSY (main reloads); accept & ~consume -> FULL (input to skid); consume & ~accept -> EMPTY.
  - FULL: in_ready_o=0; consume -> BUSY (skid moves to main, skid cleared).
  - Throughput is 1 bundle/cycle whenever out_ready_i stays high.
- Flush:
  - Synchronous; highest priority over accept and consume.
  - Next cycle: state EMPTY, out_valid_o=0, count_o=0, in_ready_o=1.
  - A bundle presented in the flush cycle is dropped.
  - flush_i during reset has no effect.
- Bubble clearing:
  - Whenever the stage is invalid (reset, flush, drain), out_ctrl_o bits set in CTRL_CLR_MASK read 0.
  - This keeps RegWrite/MemWrite deasserted on bubbles.
  - out_data_o holds its last value when invalid; the bench must not check it.
- count_o = main valid + skid valid.

Decomposition:
- Package pipe_pkg:
  - State enum {EMPTY, BUSY, FULL}.
  - EX/MEM control bit indices: CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3.
  - Default width constants.
- Single module, no sub-module; the skid entry is generated only when SKID=1.

Test Plan:
- Reset: start_i=0 mid-stream with bundles held -> out_valid_o=0, out_ctrl_o=4'b0000, count_o=0 asynchronously; in_ready_o=1 after release.
- Streaming (SKID=1, out_ready_i=1): data 1..8 on consecutive cycles -> outputs 1..8 on consecutive cycles, 1-cycle latency, in_ready_o never low.
- Backpressure (SKID=1): accept 0xA, 0xB while out_ready_i=0 -> count_o=2, in_ready_o=0, out_data_o holds 0xA. Raise out_ready_i -> 0xA then 0xB, count_o goes 2, 1, 0.
- Stall (SKID=0): out_ready_i=0 with out_valid_o=1 -> in_ready_o=0 and output stable for 5 cycles; release -> next bundle on the following cycle.
- Flush in FULL with in_valid_i=1 and ctrl=4'b1001 -> next cycle out_valid_o=0, out_ctrl_o=0, count_o=0; the flushed-cycle input never appears at the output.
- Simultaneous accept and consume in BUSY -> count_o stays 1; output advances to the new bundle.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared types and constants for the generic pipeline-stage register.
//   state_t           occupancy state of a stage (EMPTY / BUSY / FULL)
//   CTRL_*            EX/MEM control bundle bit positions
//   DATA_W_DEF/CTRL_W_DEF  default bundle widths
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMREAD  = 2;
    localparam int unsigned CTRL_MEMWRITE = 3;

    localparam int unsigned DATA_W_DEF = 69;
    localparam int unsigned CTRL_W_DEF = 4;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline-stage register with valid/ready
// handshake, stall hold, synchronous flush and bubble control clearing.
// Ports:
//   clk_i        clock, rising edge
//   start_i      asynchronous active-low reset
//   flush_i      synchronous flush, overrides accept and consume
//   in_valid_i / in_ready_o / in_ctrl_i / in_data_i      upstream side
//   out_valid_o / out_ready_i / out_ctrl_o / out_data_o  downstream side
//   count_o      number of held bundles (0..2, 0..1 when SKID=0)
// SKID=0 gives a single stall register with combinational ready;
// SKID=1 adds a skid entry so in_ready_o comes straight from a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W        = DATA_W_DEF,
    parameter int unsigned        CTRL_W        = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0]  CTRL_CLR_MASK = '1,
    parameter bit                 SKID          = 1'b0
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    state_t             state_q, state_d;
    logic               main_valid, skid_valid;
    logic               accept, consume;
    logic               load_main, main_from_skid;
    logic               in_ready;
    logic [DATA_W-1:0]  main_data, skid_data, main_data_d;
    logic [CTRL_W-1:0]  main_ctrl, skid_ctrl, main_ctrl_d;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);
    assign accept     = in_valid_i & in_ready;
    assign consume    = main_valid & out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = BUSY;
                        load_main = 1'b1;
                    end
                end
                BUSY: begin
                    // With SKID=0 an accept in BUSY always coincides with a
                    // consume, so FULL is only reachable with the skid entry.
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d        = BUSY;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_data_d = main_from_skid ? skid_data : in_data_i;
    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl_i;

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q   <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_data <= main_data_d;
                main_ctrl <= main_ctrl_d;
            end
        end
    end

    generate
        if (SKID) begin : g_skid
            logic ready_q;

            // Ready is precomputed from the next state so the upstream sees
            // a pure flop output.
            always_ff @(posedge clk_i or negedge start_i) begin
                if (!start_i) begin
                    skid_data <= '0;
                    skid_ctrl <= '0;
                    ready_q   <= 1'b1;
                end else begin
                    if (state_q == BUSY && state_d == FULL) begin
                        skid_data <= in_data_i;
                        skid_ctrl <= in_ctrl_i;
                    end
                    ready_q <= (state_d != FULL);
                end
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            assign skid_data = '0;
            assign skid_ctrl = '0;
            assign in_ready  = out_ready_i | ~main_valid;
        end
    endgenerate

    assign in_ready_o  = in_ready;
    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;
    // Bubbles read back with masked control bits cleared.
    assign out_ctrl_o  = main_valid ? main_ctrl : (main_ctrl & ~CTRL_CLR_MASK);
    assign count_o     = {skid_valid, main_valid & ~skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives one SKID=1 and one SKID=0 instance of
// pipe_stage_reg with directed steps; a per-instance queue holds the
// bundles expected at the output in order.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = DATA_W_DEF;
    localparam int unsigned CW = CTRL_W_DEF;

    logic clk = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    // SKID=1 instance signals
    logic          s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [CW-1:0] s_in_ctrl = '0;
    logic [DW-1:0] s_in_data = '0;
    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_count;

    // SKID=0 instance signals
    logic          t_flush = 1'b0, t_in_valid = 1'b0, t_out_ready = 1'b0;
    logic [CW-1:0] t_in_ctrl = '0;
    logic [DW-1:0] t_in_data = '0;
    logic          t_in_ready, t_out_valid;
    logic [CW-1:0] t_out_ctrl;
    logic [DW-1:0] t_out_data;
    logic [1:0]    t_count;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_CLR_MASK(4'b1111), .SKID(1'b1)) u_skid (
        .clk_i(clk), .start_i(start), .flush_i(s_flush),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .in_ctrl_i(s_in_ctrl), .in_data_i(s_in_data),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .out_ctrl_o(s_out_ctrl), .out_data_o(s_out_data), .count_o(s_count)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_CLR_MASK(4'b1111), .SKID(1'b0)) u_stall (
        .clk_i(clk), .start_i(start), .flush_i(t_flush),
        .in_valid_i(t_in_valid), .in_ready_o(t_in_ready),
        .in_ctrl_i(t_in_ctrl), .in_data_i(t_in_data),
        .out_valid_o(t_out_valid), .out_ready_i(t_out_ready),
        .out_ctrl_o(t_out_ctrl), .out_data_o(t_out_data), .count_o(t_count)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [DW-1:0] qd_s[$], qd_t[$];
    logic [CW-1:0] qc_s[$], qc_t[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the selected instance (1 = SKID, 0 = stall).
    // Called at posedge+1; drives inputs, checks outputs against the
    // queue, updates the queue for the coming edge, returns at posedge+1.
    task automatic step(input bit sel, input logic v, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic r, input logic fl);
        logic          ov, ir, exp_ready, acc, con;
        logic [1:0]    cnt;
        logic [CW-1:0] oc;
        logic [DW-1:0] od;
        int unsigned   sz;
        if (sel) begin
            s_in_valid = v; s_in_data = d; s_in_ctrl = c; s_out_ready = r; s_flush = fl;
        end else begin
            t_in_valid = v; t_in_data = d; t_in_ctrl = c; t_out_ready = r; t_flush = fl;
        end
        #1;
        if (sel) begin
            ov = s_out_valid; ir = s_in_ready; cnt = s_count; oc = s_out_ctrl; od = s_out_data;
            sz = qd_s.size();
            exp_ready = (sz < 2);
        end else begin
            ov = t_out_valid; ir = t_in_ready; cnt = t_count; oc = t_out_ctrl; od = t_out_data;
            sz = qd_t.size();
            exp_ready = r || (sz == 0);
        end
        chk(sel ? "skid_valid" : "stall_valid", DW'(ov), DW'(sz > 0));
        chk(sel ? "skid_count" : "stall_count", DW'(cnt), DW'(sz));
        chk(sel ? "skid_ready" : "stall_ready", DW'(ir), DW'(exp_ready));
        if (sz > 0) begin
            chk(sel ? "skid_data" : "stall_data", od, sel ? qd_s[0] : qd_t[0]);
            chk(sel ? "skid_ctrl" : "stall_ctrl", DW'(oc), DW'(sel ? qc_s[0] : qc_t[0]));
        end else begin
            chk(sel ? "skid_bubble_ctrl" : "stall_bubble_ctrl", DW'(oc), '0);
        end
        acc = v && exp_ready;
        con = (sz > 0) && r;
        if (fl) begin
            if (sel) begin qd_s.delete(); qc_s.delete(); end
            else     begin qd_t.delete(); qc_t.delete(); end
        end else begin
            if (con) begin
                if (sel) begin void'(qd_s.pop_front()); void'(qc_s.pop_front()); end
                else     begin void'(qd_t.pop_front()); void'(qc_t.pop_front()); end
            end
            if (acc) begin
                if (sel) begin qd_s.push_back(d); qc_s.push_back(c); end
                else     begin qd_t.push_back(d); qc_t.push_back(c); end
            end
        end
        @(posedge clk);
        #1;
        if (sel) begin s_in_valid = 1'b0; s_flush = 1'b0; end
        else     begin t_in_valid = 1'b0; t_flush = 1'b0; end
    endtask

    logic [CW-1:0] ctrl_rw_mw;

    initial begin
        ctrl_rw_mw = '0;
        ctrl_rw_mw[CTRL_REGWRITE] = 1'b1;
        ctrl_rw_mw[CTRL_MEMWRITE] = 1'b1;

        // Power-on reset, flush asserted meanwhile must not matter
        s_flush = 1'b1; t_flush = 1'b1;
        #1;
        chk("por_skid_valid", DW'(s_out_valid), '0);
        chk("por_skid_count", DW'(s_count), '0);
        chk("por_stall_valid", DW'(t_out_valid), '0);
        chk("por_skid_data", s_out_data, '0);
        @(posedge clk); #1;
        s_flush = 1'b0; t_flush = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;

        // Streaming through the skid buffer, one bundle per cycle
        for (int i = 1; i <= 8; i++)
            step(1'b1, 1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: fill both entries, then drain
        step(1'b1, 1'b1, DW'('hA), 4'h3, 1'b0, 1'b0);
        step(1'b1, 1'b1, DW'('hB), 4'h5, 1'b0, 1'b0);
        step(1'b1, 1'b1, DW'('hC), 4'h7, 1'b0, 1'b0); // refused, stage full
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);

        // Simultaneous accept and consume in BUSY
        step(1'b1, 1'b1, DW'('h11), 4'h1, 1'b0, 1'b0);
        step(1'b1, 1'b1, DW'('h22), 4'h2, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

        // Flush while FULL with a bundle presented
        step(1'b1, 1'b1, DW'('h33), 4'h4, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, DW'('hDEAD), ctrl_rw_mw, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b1, DW'('h44), 4'h6, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);

        // Stall register: hold for 5 cycles, then release
        step(1'b0, 1'b1, DW'('h55), 4'h9, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, DW'('h66), 4'hA, 1'b0, 1'b0);
        step(1'b0, 1'b1, DW'('h66), 4'hA, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        // Back-to-back through the stall register, then a flush with input
        step(1'b0, 1'b1, DW'('h70), 4'h1, 1'b1, 1'b0);
        step(1'b0, 1'b1, DW'('h71), 4'h2, 1'b1, 1'b0);
        step(1'b0, 1'b1, DW'('h72), ctrl_rw_mw, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset with bundles held in both instances
        step(1'b0, 1'b1, DW'('h80), 4'hF, 1'b0, 1'b0);
        step(1'b1, 1'b1, DW'('h81), 4'hF, 1'b0, 1'b0);
        step(1'b1, 1'b1, DW'('h82), 4'hF, 1'b0, 1'b0);
        chk("pre_rst_skid_count", DW'(s_count), DW'(2));
        chk("pre_rst_stall_count", DW'(t_count), DW'(1));
        #2;
        start = 1'b0;
        #1;
        chk("rst_skid_valid", DW'(s_out_valid), '0);
        chk("rst_skid_ctrl", DW'(s_out_ctrl), '0);
        chk("rst_skid_count", DW'(s_count), '0);
        chk("rst_skid_data", s_out_data, '0);
        chk("rst_stall_valid", DW'(t_out_valid), '0);
        chk("rst_stall_ctrl", DW'(t_out_ctrl), '0);
        chk("rst_stall_count", DW'(t_count), '0);
        qd_s.delete(); qc_s.delete(); qd_t.delete(); qc_t.delete();
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("rel_skid_ready", DW'(s_in_ready), DW'(1));
        chk("rel_stall_ready", DW'(t_in_ready), DW'(1));
        @(posedge clk); #1;
        step(1'b1, 1'b1, DW'('h90), 4'h8, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
